ctrl_pipe_regs: RTL
===================

// Module: ctrl_pipe_regs
// PURPOSE
//  Receiving end of the ControlUnit bundles. Carries decoded EX[3:0]={RegDst,ALUOp[1:0],ALUSrc},
//  MEM[2:0]={MemRead,MemWrite,Branch} and WB[1:0]={RegWrite,MemtoReg} through ID/EX, EX/MEM and
//  MEM/WB. Drives the per-stage control lines, load-use stall, branch flush and forwarding selects
//  for the 5-stage MIPS datapath (R-type, andi, lw, sw, beq, j, jr). Keeps stall/flush event counters.
// PARAMETERS
//  CNT_W   16  width of the saturating stall_cnt / flush_cnt counters
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  id_valid     in   1   ID holds a real instruction; 0 = bubble
//  id_EX        in   4   EX bundle from ControlUnit
//  id_MEM       in   3   MEM bundle from ControlUnit
//  id_WB        in   2   WB bundle from ControlUnit
//  id_Jump      in   1   Jump from ControlUnit (j / jr)
//  id_rs,id_rt,id_rd in 5 register fields of the ID instruction
//  mem_zero     in   1   ALU zero registered into EX/MEM
//  ex_RegDst,ex_ALUSrc out 1; ex_ALUOp out 2   EX-stage controls
//  ex_rs,ex_rt  out  5   ID/EX source fields
//  mem_MemRead,mem_MemWrite,mem_Branch out 1   MEM-stage controls
//  wb_RegWrite,wb_MemtoReg out 1   WB-stage controls
//  mem_dst,wb_dst out 5  destination register in MEM / WB
//  fwd_a,fwd_b  out  2   ALU operand select: 00 regfile, 10 from EX/MEM, 01 from MEM/WB
//  stall        out  1   hold PC and IF/ID, bubble into ID/EX
//  pc_src       out  1   branch taken (mem_Branch & mem_zero)
//  if_flush     out  1   squash IF/ID this edge
//  stall_cnt,flush_cnt out CNT_W   saturating event counters
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage controls, ex_rs/ex_rt, dst fields and counters = 0; no
//    outputs X. Combinational outputs then read 0 (fwd=00, stall=0, pc_src=0, if_flush=0).
//  - Register slots load on each rising edge; one cycle per stage (ID->EX->MEM->WB, latency 1 each).
//  - Bubble = all control bits 0 and dst 0. ID/EX loads a bubble when id_valid=0, stall=1 or pc_src=1.
//    EX/MEM loads a bubble when pc_src=1. MEM/WB always takes EX/MEM.
//  - Don't-care bits from ControlUnit: when RegWrite=0, ex dst = 0 regardless of RegDst (may be X).
//    Stored RegDst/MemtoReg for non-writing ops are forced 0 so no X propagates.
//  - ex dst = RegDst ? rd : rt (rd/rt captured in ID/EX); carried to mem_dst, wb_dst.
//  - stall = ex MemRead & ex_dst!=0 & (ex_dst==id_rs | ex_dst==id_rt) & id_valid & ~pc_src.
//    Lasts exactly 1 cycle per load-use pair (bubble clears ex MemRead).
//  - pc_src = mem_Branch & mem_zero. if_flush = pc_src | (id_Jump & id_valid & ~stall).
//  - Priority: pc_src beats stall (older branch squashes ID, so stall forced 0 in that cycle).
//  - fwd_a: 10 if mem RegWrite & mem_dst!=0 & mem_dst==ex_rs; else 01 if wb RegWrite &
//    wb_dst!=0 & wb_dst==ex_rs; else 00. fwd_b identical with ex_rt. EX/MEM wins over MEM/WB.
//  - $zero is never forwarded and never triggers a stall.
//  - stall_cnt +1 per cycle stall=1; flush_cnt +1 per cycle pc_src=1. Both saturate at
//    2^CNT_W-1, never wrap. Reset mid-operation clears every stage immediately; in-flight work is dropped.
// TESTING
//  - Reset: rst_n low mid-stream with lw in EX -> all outputs 0 asynchronously; first valid
//    instruction after release reaches wb_RegWrite exactly 3 edges later.
//  - Load-use: lw $8 then add $9,$8,$10 -> stall=1 one cycle, stall_cnt 0->1, ID/EX bubble,
//    then fwd_a=01 for the add in EX.
//  - Forward priority: add $8 then sub $8 then or $11,$8,$8 -> or in EX sees fwd_a=fwd_b=10.
//  - Branch: beq with mem_zero=1 -> pc_src=1, if_flush=1, EX/MEM and ID/EX bubbled,
//    flush_cnt+1. With mem_zero=0 -> no squash.
//  - Branch vs stall same cycle: beq taken in MEM while lw/use pair in EX/ID -> stall=0, pc_src=1.
//  - $zero and saturation: writes to $0 -> fwd=00, no stall. Force stall_cnt to 16'hFFFF, one more stall -> stays FFFF.

Source files
------------

// File: rtl/ctrl_pipe_regs.sv
// Pipeline control registers for a 5-stage MIPS datapath: carries ControlUnit bundles
// through ID/EX, EX/MEM and MEM/WB and derives stall, flush and forwarding selects.
module ctrl_pipe_regs #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [3:0]       id_EX,
   input  logic [2:0]       id_MEM,
   input  logic [1:0]       id_WB,
   input  logic             id_Jump,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic             mem_zero,
   output logic             ex_RegDst,
   output logic             ex_ALUSrc,
   output logic [1:0]       ex_ALUOp,
   output logic [4:0]       ex_rs,
   output logic [4:0]       ex_rt,
   output logic             mem_MemRead,
   output logic             mem_MemWrite,
   output logic             mem_Branch,
   output logic             wb_RegWrite,
   output logic             wb_MemtoReg,
   output logic [4:0]       mem_dst,
   output logic [4:0]       wb_dst,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             stall,
   output logic             pc_src,
   output logic             if_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic       ex_memread_r;
   logic       ex_memwrite_r;
   logic       ex_branch_r;
   logic       ex_regwrite_r;
   logic       ex_memtoreg_r;
   logic [4:0] ex_rd_r;
   logic       mem_regwrite_r;
   logic       mem_memtoreg_r;
   logic [4:0] ex_dst_s;
   logic       id_bubble_s;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       mem_rw,
                                          input logic [4:0] mem_d,
                                          input logic       wb_rw,
                                          input logic [4:0] wb_d);
      logic [1:0] sel;
      if (mem_rw && (mem_d != 5'd0) && (mem_d == src)) begin
         sel = 2'b10;
      end else if (wb_rw && (wb_d != 5'd0) && (wb_d == src)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt == CNT_MAX) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Destination of the EX instruction; a non-writing op never names a register.
   always_comb begin
      ex_dst_s = 5'd0;
      if (ex_regwrite_r) begin
         ex_dst_s = ex_RegDst ? ex_rd_r : ex_rt;
      end else begin
         ex_dst_s = 5'd0;
      end
   end

   // Hazard detection: a taken branch in MEM squashes ID, so it overrides the load-use stall.
   always_comb begin
      pc_src      = mem_Branch & mem_zero;
      stall       = ex_memread_r & (ex_dst_s != 5'd0) &
                    ((ex_dst_s == id_rs) | (ex_dst_s == id_rt)) & id_valid & ~pc_src;
      if_flush    = pc_src | (id_Jump & id_valid & ~stall);
      id_bubble_s = ~id_valid | stall | pc_src;
      fwd_a       = fwd_sel(ex_rs, mem_regwrite_r, mem_dst, wb_RegWrite, wb_dst);
      fwd_b       = fwd_sel(ex_rt, mem_regwrite_r, mem_dst, wb_RegWrite, wb_dst);
   end

   // ID/EX slot; RegDst/MemtoReg are masked by RegWrite so don't-care bits never propagate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_RegDst     <= 1'b0;
         ex_ALUOp      <= 2'b00;
         ex_ALUSrc     <= 1'b0;
         ex_memread_r  <= 1'b0;
         ex_memwrite_r <= 1'b0;
         ex_branch_r   <= 1'b0;
         ex_regwrite_r <= 1'b0;
         ex_memtoreg_r <= 1'b0;
         ex_rs         <= 5'd0;
         ex_rt         <= 5'd0;
         ex_rd_r       <= 5'd0;
      end else if (id_bubble_s) begin
         ex_RegDst     <= 1'b0;
         ex_ALUOp      <= 2'b00;
         ex_ALUSrc     <= 1'b0;
         ex_memread_r  <= 1'b0;
         ex_memwrite_r <= 1'b0;
         ex_branch_r   <= 1'b0;
         ex_regwrite_r <= 1'b0;
         ex_memtoreg_r <= 1'b0;
         ex_rs         <= 5'd0;
         ex_rt         <= 5'd0;
         ex_rd_r       <= 5'd0;
      end else begin
         ex_RegDst     <= id_EX[3] & id_WB[1];
         ex_ALUOp      <= id_EX[2:1];
         ex_ALUSrc     <= id_EX[0];
         ex_memread_r  <= id_MEM[2];
         ex_memwrite_r <= id_MEM[1];
         ex_branch_r   <= id_MEM[0];
         ex_regwrite_r <= id_WB[1];
         ex_memtoreg_r <= id_WB[0] & id_WB[1];
         ex_rs         <= id_rs;
         ex_rt         <= id_rt;
         ex_rd_r       <= id_rd;
      end
   end

   // EX/MEM slot, squashed when the branch ahead of it is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_MemRead    <= 1'b0;
         mem_MemWrite   <= 1'b0;
         mem_Branch     <= 1'b0;
         mem_regwrite_r <= 1'b0;
         mem_memtoreg_r <= 1'b0;
         mem_dst        <= 5'd0;
      end else if (pc_src) begin
         mem_MemRead    <= 1'b0;
         mem_MemWrite   <= 1'b0;
         mem_Branch     <= 1'b0;
         mem_regwrite_r <= 1'b0;
         mem_memtoreg_r <= 1'b0;
         mem_dst        <= 5'd0;
      end else begin
         mem_MemRead    <= ex_memread_r;
         mem_MemWrite   <= ex_memwrite_r;
         mem_Branch     <= ex_branch_r;
         mem_regwrite_r <= ex_regwrite_r;
         mem_memtoreg_r <= ex_memtoreg_r;
         mem_dst        <= ex_dst_s;
      end
   end

   // MEM/WB slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_RegWrite <= 1'b0;
         wb_MemtoReg <= 1'b0;
         wb_dst      <= 5'd0;
      end else begin
         wb_RegWrite <= mem_regwrite_r;
         wb_MemtoReg <= mem_memtoreg_r;
         wb_dst      <= mem_dst;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= {CNT_W{1'b0}};
         flush_cnt <= {CNT_W{1'b0}};
      end else begin
         stall_cnt <= stall  ? sat_inc(stall_cnt) : stall_cnt;
         flush_cnt <= pc_src ? sat_inc(flush_cnt) : flush_cnt;
      end
   end

endmodule
